uart_tx_serializer: RTL and testbench



---
 rtl/uart_pkg.sv | 24 ++
 rtl/uart_tx_serializer_if.sv | 11 +
 rtl/uart_baud_cnt.sv | 30 +++
 rtl/uart_tx_serializer.sv | 132 +++++++++++++
 tb/tb_uart_tx_serializer.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, parity selectors and default bit timing.
package uart_pkg;

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_START  = 3'd1;
   localparam logic [2:0] ST_DATA   = 3'd2;
   localparam logic [2:0] ST_PARITY = 3'd3;
   localparam logic [2:0] ST_STOP   = 3'd4;

   typedef enum logic [2:0] {
      IDLE   = ST_IDLE,
      START  = ST_START,
      DATA   = ST_DATA,
      PARITY = ST_PARITY,
      STOP   = ST_STOP
   } tx_state_e;

   localparam bit PARITY_EVEN = 1'b0;
   localparam bit PARITY_ODD  = 1'b1;

   // 100 MHz system clock at 115200 baud
   localparam int DEFAULT_CLKS_PER_BIT = 868;

endpackage

// File: rtl/uart_tx_serializer_if.sv
// Fall-through fifo read port between the TX fifo and the serializer.
interface uart_tx_serializer_if #(
   parameter int DATA_W = 8
);
   logic [DATA_W-1:0] fifo_data;
   logic              fifo_empty;
   logic              fifo_pop;

   modport master (input fifo_data, input fifo_empty, output fifo_pop);
   modport slave  (output fifo_data, output fifo_empty, input fifo_pop);
endinterface

// File: rtl/uart_baud_cnt.sv
// Loadable baud down-counter; bit_done marks the last clock of a serial bit.
module uart_baud_cnt
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
   input  logic clk,
   input  logic rst,
   input  logic load,
   output logic bit_done
);

   localparam int               CNT_W    = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(CLKS_PER_BIT - 1);

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= LOAD_VAL;
      end else if (cnt != '0) begin
         cnt <= cnt - CNT_W'(1);
      end
   end

   assign bit_done = (cnt == '0);

endmodule

// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: pops words from a fall-through fifo and frames them
// as start, LSB-first data, optional parity and 1-2 stop bits on a registered tx.
module uart_tx_serializer
   import uart_pkg::*;
#(
   parameter int DATA_W       = 8,
   parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
   parameter bit PARITY_EN    = 1'b0,
   parameter bit PARITY_MODE  = PARITY_EVEN,
   parameter int STOP_BITS    = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  enable,
   uart_tx_serializer_if.master  fifo,
   output logic                  tx,
   output logic                  busy
);

   localparam int               IDX_W     = $clog2(DATA_W + 1);
   localparam logic [IDX_W-1:0] LAST_DATA = IDX_W'(DATA_W - 1);
   localparam logic [IDX_W-1:0] LAST_STOP = IDX_W'(STOP_BITS - 1);

   tx_state_e         state, state_d;
   logic [DATA_W-1:0] shift_q, shift_d;
   logic              par_q, par_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic              load, bit_done, take, tx_d;

   function automatic logic parity_of(input logic [DATA_W-1:0] word);
      return (^word) ^ PARITY_MODE;
   endfunction

   uart_baud_cnt #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
      .clk      (clk),
      .rst      (rst),
      .load     (load),
      .bit_done (bit_done)
   );

   always_comb begin
      state_d = state;
      shift_d = shift_q;
      par_d   = par_q;
      idx_d   = idx_q;
      load    = 1'b0;
      take    = 1'b0;
      case (state)
         IDLE: begin
            if (enable && !fifo.fifo_empty) take = 1'b1;
         end
         START: begin
            if (bit_done) begin
               state_d = DATA;
               idx_d   = '0;
               load    = 1'b1;
            end
         end
         DATA: begin
            if (bit_done) begin
               shift_d = shift_q >> 1;
               load    = 1'b1;
               if (idx_q == LAST_DATA) begin
                  idx_d = '0;
                  if (PARITY_EN) state_d = PARITY;
                  else           state_d = STOP;
               end else begin
                  idx_d = idx_q + IDX_W'(1);
               end
            end
         end
         PARITY: begin
            if (bit_done) begin
               state_d = STOP;
               idx_d   = '0;
               load    = 1'b1;
            end
         end
         STOP: begin
            if (bit_done) begin
               if (idx_q == LAST_STOP) begin
                  idx_d = '0;
                  // Chain straight into the next frame to avoid an idle gap
                  if (enable && !fifo.fifo_empty) take = 1'b1;
                  else                            state_d = IDLE;
               end else begin
                  idx_d = idx_q + IDX_W'(1);
                  load  = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      if (take) begin
         state_d = START;
         shift_d = fifo.fifo_data;
         par_d   = parity_of(fifo.fifo_data);
         load    = 1'b1;
      end

      // tx is registered, so it is derived from the state being entered
      case (state_d)
         START:   tx_d = 1'b0;
         DATA:    tx_d = shift_d[0];
         PARITY:  tx_d = par_d;
         default: tx_d = 1'b1;
      endcase
   end

   assign fifo.fifo_pop = take & ~rst;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         idx_q <= '0;
         tx    <= 1'b1;
         busy  <= 1'b0;
      end else begin
         state <= state_d;
         idx_q <= idx_d;
         tx    <= tx_d;
         busy  <= (state_d != IDLE);
      end
   end

   always_ff @(posedge clk) begin
      shift_q <= shift_d;
      par_q   <= par_d;
   end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Bench for uart_tx_serializer: four configurations driven in lockstep, each
// checked against a bit-level frame model through an expected-frame scoreboard.
module tb_uart_tx_serializer;
   import uart_pkg::*;

   localparam int CPB   = 4;
   localparam int NL    = 4;
   localparam int DEPTH = 128;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst;
   logic       en     [NL];
   logic       fempty [NL];
   logic [7:0] fdata  [NL];
   logic       pop_w  [NL];
   logic       tx_w   [NL];
   logic       busy_w [NL];

   // Lane configs: 0 plain, 1 even parity, 2 odd parity, 3 two stop bits
   function automatic int pen(input int l);
      return (l == 1 || l == 2) ? 1 : 0;
   endfunction
   function automatic int podd(input int l);
      return (l == 2) ? 1 : 0;
   endfunction
   function automatic int sb(input int l);
      return (l == 3) ? 2 : 1;
   endfunction

   for (genvar g = 0; g < NL; g++) begin : lane
      localparam bit PEN = (g == 1 || g == 2);
      localparam bit PMD = (g == 2) ? PARITY_ODD : PARITY_EVEN;
      localparam int SB  = (g == 3) ? 2 : 1;
      uart_tx_serializer_if #(.DATA_W(8)) ifc ();
      logic tx_o, busy_o;
      assign ifc.fifo_data  = fdata[g];
      assign ifc.fifo_empty = fempty[g];
      assign pop_w[g]       = ifc.fifo_pop;
      assign tx_w[g]        = tx_o;
      assign busy_w[g]      = busy_o;
      uart_tx_serializer #(
         .DATA_W(8), .CLKS_PER_BIT(CPB), .PARITY_EN(PEN),
         .PARITY_MODE(PMD), .STOP_BITS(SB)
      ) dut (
         .clk(clk), .rst(rst), .enable(en[g]), .fifo(ifc),
         .tx(tx_o), .busy(busy_o)
      );
   end

   // Stimulus-owned state: fifo contents and the expected-frame scoreboard
   logic [7:0]  fq [NL][$];
   logic [11:0] exp_bits [NL][DEPTH];
   int          exp_len  [NL][DEPTH];
   int          wr [NL];
   int          timeouts;
   bit          mon_en, done;

   task automatic refresh(input int l);
      fempty[l] = (fq[l].size() == 0);
      fdata[l]  = (fq[l].size() != 0) ? fq[l][0] : 8'h00;
   endtask

   task automatic push_word(input int l, input logic [7:0] w);
      logic [11:0] b;
      int n;
      b = '1;
      n = 0;
      b[n] = 1'b0; n++;
      for (int i = 0; i < 8; i++) begin b[n] = w[i]; n++; end
      if (pen(l) == 1) begin
         b[n] = (($countones(w) % 2) == 1) ^ (podd(l) == 1);
         n++;
      end
      for (int i = 0; i < sb(l); i++) begin b[n] = 1'b1; n++; end
      exp_bits[l][wr[l]] = b;
      exp_len[l][wr[l]]  = n;
      wr[l]++;
      fq[l].push_back(w);
      refresh(l);
   endtask

   task automatic push_all(input logic [7:0] w);
      for (int l = 0; l < NL; l++) push_word(l, w);
   endtask

   task automatic set_en_all(input logic v);
      for (int l = 0; l < NL; l++) en[l] = v;
   endtask

   task automatic tick();
      logic p [NL];
      @(negedge clk);
      for (int l = 0; l < NL; l++) p[l] = pop_w[l];
      @(posedge clk);
      #1;
      for (int l = 0; l < NL; l++) begin
         if (p[l] === 1'b1 && fq[l].size() != 0) void'(fq[l].pop_front());
         refresh(l);
      end
   endtask

   function automatic bit all_idle();
      for (int l = 0; l < NL; l++)
         if (fq[l].size() != 0 || busy_w[l] !== 1'b0) return 1'b0;
      return 1'b1;
   endfunction

   task automatic wait_idle(input int limit);
      int c;
      c = 0;
      while (c < limit && !all_idle()) begin tick(); c++; end
      if (!all_idle()) timeouts++;
   endtask

   initial begin
      int pushed [NL];
      rst = 1'b1; mon_en = 1'b0; done = 1'b0; timeouts = 0;
      for (int l = 0; l < NL; l++) begin
         en[l] = 1'b0; wr[l] = 0; pushed[l] = 0; refresh(l);
      end
      repeat (3) tick();
      mon_en = 1'b1;
      tick();
      rst = 1'b0;

      // Enabled but empty, then loaded but disabled
      set_en_all(1'b1);
      repeat (100) tick();
      set_en_all(1'b0);
      push_word(0, 8'hA5); push_word(1, 8'h07); push_word(2, 8'h03); push_word(3, 8'hFF);
      repeat (100) tick();
      set_en_all(1'b1);
      wait_idle(200);
      push_all(8'h00);
      wait_idle(200);

      // Back-to-back frames
      push_all(8'h55); push_all(8'h0F);
      wait_idle(400);

      // enable dropped mid-frame: frame completes, second word stays queued
      push_all(8'h3C); push_all(8'hC3);
      repeat (8) tick();
      set_en_all(1'b0);
      repeat (120) tick();
      set_en_all(1'b1);
      wait_idle(300);

      // rst in frame cycle 10 abandons the word; the next one goes out intact
      push_all(8'hA5); push_all(8'h96);
      tick();
      repeat (9) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      wait_idle(300);

      // Random traffic with random enable toggling
      for (int c = 0; c < 3000; c++) begin
         for (int l = 0; l < NL; l++) begin
            if (pushed[l] < 30 && $urandom_range(0, 99) < 3) begin
               push_word(l, 8'($urandom));
               pushed[l]++;
            end
            if ($urandom_range(0, 31) == 0) en[l] = ~en[l];
         end
         tick();
      end
      set_en_all(1'b1);
      wait_idle(3000);
      done = 1'b1;
   end

   // Monitor: owns the read side of the scoreboard and all counters
   int          tests = 0;
   int          fails = 0;
   int          cyc   = 0;
   int          rd     [NL] = '{default: 0};
   bit          active [NL] = '{default: 1'b0};
   int          pos    [NL];
   int          cl     [NL];
   logic [11:0] cb     [NL];
   bit          ferr   [NL];
   int          bpos   [NL];
   logic        btx    [NL];
   logic        bbusy  [NL];

   always @(negedge clk) begin : monitor
      logic want_pop, exp_tx;
      cyc++;
      if (mon_en) begin
         for (int l = 0; l < NL; l++) begin
            if (active[l]) begin
               exp_tx = cb[l][pos[l] / CPB];
               if ((tx_w[l] !== exp_tx || busy_w[l] !== 1'b1) && !ferr[l]) begin
                  ferr[l] = 1'b1; bpos[l] = pos[l]; btx[l] = tx_w[l]; bbusy[l] = busy_w[l];
               end
               pos[l]++;
               if (pos[l] == cl[l] * CPB || rst === 1'b1) begin
                  active[l] = 1'b0;
                  tests++;
                  if (ferr[l]) begin
                     fails++;
                     $display("FAIL frame lane%0d word#%0d cycle %0d: tx=%b busy=%b, required tx=%b busy=1",
                              l, rd[l] - 1, bpos[l], btx[l], bbusy[l], cb[l][bpos[l] / CPB]);
                  end
               end
            end else begin
               tests++;
               if (tx_w[l] !== 1'b1 || busy_w[l] !== 1'b0) begin
                  fails++;
                  $display("FAIL idle lane%0d t=%0t: tx=%b busy=%b, required tx=1 busy=0",
                           l, $time, tx_w[l], busy_w[l]);
               end
            end

            want_pop = !active[l] && en[l] && !fempty[l] && (rst === 1'b0);
            tests++;
            if (pop_w[l] !== want_pop) begin
               fails++;
               $display("FAIL pop lane%0d t=%0t: fifo_pop=%b, required %b", l, $time, pop_w[l], want_pop);
            end
            if (pop_w[l] === 1'b1 && !active[l]) begin
               if (rd[l] == wr[l]) begin
                  tests++; fails++;
                  $display("FAIL scoreboard lane%0d: pop with %0d frames expected, required none", l, 0);
               end else begin
                  cb[l] = exp_bits[l][rd[l]]; cl[l] = exp_len[l][rd[l]];
                  rd[l]++; active[l] = 1'b1; pos[l] = 0; ferr[l] = 1'b0;
               end
            end
         end
      end

      if (done || cyc > 60000) begin
         tests++;
         if (cyc > 60000 || timeouts != 0) begin
            fails++;
            $display("FAIL drain: cycles=%0d timeouts=%0d, required timeouts=0", cyc, timeouts);
         end
         for (int l = 0; l < NL; l++) begin
            tests++;
            if (rd[l] != wr[l] || active[l]) begin
               fails++;
               $display("FAIL frames lane%0d: sent %0d of %0d, required all", l, rd[l], wr[l]);
            end
         end
         $display("[TB] %0d tests run, %0d failed", tests, fails);
         $finish;
      end
   end

endmodule
